traffic_input_conditioner: RTL and testbench

Front-end stage for the traffic light controller. It runs on the board master clock and produces everything the light FSM consumes:
- the slow state clock and a matching one-cycle tick;
- a debounced, synchronized sensor level;
- a debounced walk level and a one-cycle walk press pulse.

It sits between the board pins/buttons and the light FSM, so the FSM never sees raw asynchronous inputs.

---
 rtl/traffic_pkg.sv | 30 +++
 rtl/traffic_debounce.sv | 123 ++++++++++++
 rtl/traffic_input_conditioner.sv | 80 ++++++++
 tb/tb_traffic_input_conditioner.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// traffic_pkg: types and constants shared by the traffic light front end and
// the light FSM. Holds the debounce state encoding, the synchronizer depth and
// the light-state encodings the FSM uses on its output side.
package traffic_pkg;

  // Number of flops in each raw-input synchronizer chain.
  localparam int SYNC_STAGES = 2;

  // Debounce filter states: two stable states and two qualifying states.
  typedef enum logic [1:0] {
    S_LO   = 2'b00,
    S_RISE = 2'b01,
    S_HI   = 2'b10,
    S_FALL = 2'b11
  } db_state_t;

  // Light states driven by the FSM that consumes this block's outputs.
  typedef enum logic [1:0] {
    LIGHT_MAIN_GO   = 2'b00,
    LIGHT_MAIN_WARN = 2'b01,
    LIGHT_SIDE_GO   = 2'b10,
    LIGHT_SIDE_WARN = 2'b11
  } light_state_t;

  // The filtered level is 1 while stable high or while qualifying a fall.
  function automatic logic db_level(input db_state_t s);
    return (s == S_HI) || (s == S_FALL);
  endfunction

endpackage

// File: rtl/traffic_debounce.sv
// traffic_debounce: 2-flop synchronizer, 4-state debounce filter and a
// one-cycle pulse on each rising edge of the filtered level.
// Build option TRAFFIC_INPUT_DEBOUNCE_EN: when defined the 4-state filter is
// present; when undefined the level is the synchronized input directly and
// DB_CYCLES has no effect.
module traffic_debounce
  import traffic_pkg::*;
#(
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic master_clock,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise
);

  if (DB_CYCLES < 1) begin : g_bad_db_cycles
    $error("traffic_debounce: DB_CYCLES must be at least 1");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_in;
  logic                   level_d;
  logic                   level_q;

  // Two-flop chain to bring the asynchronous pin into the master clock domain.
  always_ff @(posedge master_clock or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
    end
  end

  assign sync_in = sync_q[SYNC_STAGES-1];

`ifdef TRAFFIC_INPUT_DEBOUNCE_EN
  localparam int              CNT_W   = $clog2(DB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  db_state_t        state_q;
  db_state_t        state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Filter state and stability counter registers.
  always_ff @(posedge master_clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_LO;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: a change must be seen for DB_CYCLES consecutive cycles; the
  // counter only increments below CNT_MAX, so it can never wrap.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_LO: begin
        if (sync_in) begin
          state_d = S_RISE;
          cnt_d   = CNT_ONE;
        end
      end
      S_RISE: begin
        if (!sync_in) begin
          state_d = S_LO;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = S_HI;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_HI: begin
        if (!sync_in) begin
          state_d = S_FALL;
          cnt_d   = CNT_ONE;
        end
      end
      S_FALL: begin
        if (sync_in) begin
          state_d = S_HI;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = S_LO;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = S_LO;
        cnt_d   = '0;
      end
    endcase
  end

  assign level_d = db_level(state_q);
`else
  assign level_d = sync_in;
`endif

  // Previous filtered level, used to find the first cycle the level reads 1.
  always_ff @(posedge master_clock or negedge reset) begin
    if (!reset) begin
      level_q <= 1'b0;
    end else begin
      level_q <= level_d;
    end
  end

  assign level = level_d;
  assign rise  = level_d & ~level_q;

endmodule

// File: rtl/traffic_input_conditioner.sv
// traffic_input_conditioner: front end for the traffic light controller.
// Generates the slow state clock and its one-cycle tick from the master clock,
// and conditions the walk button and side-road sensor so the light FSM never
// sees raw asynchronous inputs.
// Build option TRAFFIC_INPUT_DEBOUNCE_EN: enables the 4-state debounce filters;
// without it the levels are the synchronized inputs (2-edge latency).
module traffic_input_conditioner
  import traffic_pkg::*;
#(
  parameter int CLK_HZ    = 100_000_000,
  parameter int TICK_HZ   = 1,
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic master_clock,
  input  logic reset,
  input  logic walk_raw,
  input  logic sensor_raw,
  output logic slow_clock,
  output logic tick,
  output logic walk_level,
  output logic walk_press,
  output logic sensor_level
);

  localparam int DIV   = CLK_HZ / TICK_HZ;
  localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;

  localparam logic [CNT_W-1:0] CNT_HALF_END = CNT_W'(DIV / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_END      = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  if ((DIV < 2) || ((DIV % 2) != 0)) begin : g_bad_div
    $error("traffic_input_conditioner: CLK_HZ/TICK_HZ must be even and at least 2");
  end

  logic [CNT_W-1:0] div_cnt_q;
  logic             half_end;
  logic             full_end;
  logic             sensor_press_unused;

  assign half_end = (div_cnt_q == CNT_HALF_END);
  assign full_end = (div_cnt_q == CNT_END);

  // Divider: count 0..DIV-1, toggle slow_clock at each half period and mark
  // the low-to-high transition with a registered one-cycle tick.
  always_ff @(posedge master_clock or negedge reset) begin
    if (!reset) begin
      div_cnt_q  <= '0;
      slow_clock <= 1'b0;
      tick       <= 1'b0;
    end else begin
      div_cnt_q <= full_end ? '0 : (div_cnt_q + CNT_ONE);
      if (half_end || full_end) begin
        slow_clock <= ~slow_clock;
      end
      tick <= half_end;
    end
  end

  traffic_debounce #(
    .DB_CYCLES(DB_CYCLES)
  ) u_walk_debounce (
    .master_clock(master_clock),
    .reset       (reset),
    .raw         (walk_raw),
    .level       (walk_level),
    .rise        (walk_press)
  );

  traffic_debounce #(
    .DB_CYCLES(DB_CYCLES)
  ) u_sensor_debounce (
    .master_clock(master_clock),
    .reset       (reset),
    .raw         (sensor_raw),
    .level       (sensor_level),
    .rise        (sensor_press_unused)
  );

endmodule

// File: tb/tb_traffic_input_conditioner.sv
// Directed bench for traffic_input_conditioner with DIV=8 and DB_CYCLES=4.
// Edges are numbered from 1 = first rising edge after reset release; outputs
// are sampled 1 time unit after each rising edge.
module tb_traffic_input_conditioner;

  localparam int DB = 4;
`ifdef TRAFFIC_INPUT_DEBOUNCE_EN
  localparam bit DEB = 1'b1;
  localparam int OFS = DB + 2;
`else
  localparam bit DEB = 1'b0;
  localparam int OFS = 1;
`endif

  logic master_clock;
  logic reset;
  logic walk_raw;
  logic sensor_raw;
  logic slow_clock;
  logic tick;
  logic walk_level;
  logic walk_press;
  logic sensor_level;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;

  traffic_input_conditioner #(
    .CLK_HZ   (8),
    .TICK_HZ  (1),
    .DB_CYCLES(DB)
  ) dut (
    .master_clock(master_clock),
    .reset       (reset),
    .walk_raw    (walk_raw),
    .sensor_raw  (sensor_raw),
    .slow_clock  (slow_clock),
    .tick        (tick),
    .walk_level  (walk_level),
    .walk_press  (walk_press),
    .sensor_level(sensor_level)
  );

  initial begin
    master_clock = 1'b0;
    forever #5 master_clock = ~master_clock;
  end

  task automatic step();
    @(posedge master_clock);
    #1;
    edge_n++;
  endtask

  task automatic do_reset();
    reset      = 1'b0;
    walk_raw   = 1'b0;
    sensor_raw = 1'b0;
    repeat (2) @(posedge master_clock);
    @(negedge master_clock);
    reset  = 1'b1;
    edge_n = 0;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({slow_clock, tick, walk_level, walk_press, sensor_level} !== 5'b0) begin
      errors++;
      $display("FAIL reset_async: got outs=%b, expected 00000",
               {slow_clock, tick, walk_level, walk_press, sensor_level});
    end
    walk_raw   = 1'b1;
    sensor_raw = 1'b1;
    repeat (4) @(posedge master_clock);
    #1;
    checks++;
    if ({slow_clock, tick, walk_level, walk_press, sensor_level} !== 5'b0) begin
      errors++;
      $display("FAIL reset_held: got outs=%b, expected 00000",
               {slow_clock, tick, walk_level, walk_press, sensor_level});
    end
  endtask

  task automatic test_divider();
    logic exp_slow;
    logic exp_tick;
    do_reset();
    for (int i = 0; i < 24; i++) begin
      step();
      exp_slow = ((edge_n % 8) >= 4);
      exp_tick = ((edge_n % 8) == 4);
      checks++;
      if ({slow_clock, tick} !== {exp_slow, exp_tick}) begin
        errors++;
        $display("FAIL divider edge %0d: got slow=%b tick=%b, expected slow=%b tick=%b",
                 edge_n, slow_clock, tick, exp_slow, exp_tick);
      end
    end
  endtask

  task automatic test_walk();
    logic exp_l;
    logic exp_p;
    int   presses;
    do_reset();
    repeat (9) step();
    walk_raw = 1'b1;
    presses  = 0;
    for (int i = 0; i < 11; i++) begin
      step();
      exp_l = (edge_n >= 10 + OFS);
      exp_p = (edge_n == 10 + OFS);
      presses += int'(walk_press);
      checks++;
      if ({walk_level, walk_press} !== {exp_l, exp_p}) begin
        errors++;
        $display("FAIL walk_rise edge %0d: got level=%b press=%b, expected level=%b press=%b",
                 edge_n, walk_level, walk_press, exp_l, exp_p);
      end
    end
    checks++;
    if (presses != 1) begin
      errors++;
      $display("FAIL walk_press_count: got %0d pulses, expected 1", presses);
    end
    walk_raw = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      exp_l = (edge_n < 21 + OFS);
      checks++;
      if ({walk_level, walk_press} !== {exp_l, 1'b0}) begin
        errors++;
        $display("FAIL walk_release edge %0d: got level=%b press=%b, expected level=%b press=0",
                 edge_n, walk_level, walk_press, exp_l);
      end
    end
  endtask

  task automatic test_glitch();
    logic exp_l;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      sensor_raw = (edge_n >= 5) && (edge_n < 8);
      step();
      exp_l = DEB ? 1'b0 : ((edge_n >= 7) && (edge_n <= 9));
      checks++;
      if ({sensor_level, walk_press} !== {exp_l, 1'b0}) begin
        errors++;
        $display("FAIL sensor_glitch edge %0d: got level=%b walk_press=%b, expected level=%b walk_press=0",
                 edge_n, sensor_level, walk_press, exp_l);
      end
    end
  endtask

  task automatic test_bounce();
    logic exp_l;
    do_reset();
    for (int i = 0; i < 18; i++) begin
      sensor_raw = (edge_n == 4) || (edge_n >= 6);
      step();
      exp_l = DEB ? (edge_n >= 13) : ((edge_n == 6) || (edge_n >= 8));
      checks++;
      if (sensor_level !== exp_l) begin
        errors++;
        $display("FAIL sensor_bounce edge %0d: got level=%b, expected level=%b",
                 edge_n, sensor_level, exp_l);
      end
    end
  endtask

  task automatic test_reset_midop();
    logic exp_l;
    logic exp_p;
    logic exp_slow;
    logic exp_tick;
    do_reset();
    walk_raw = 1'b1;
    repeat (5) step();
    exp_l = (edge_n >= 1 + OFS);
    checks++;
    if ({slow_clock, walk_level} !== {1'b1, exp_l}) begin
      errors++;
      $display("FAIL midop_pre edge %0d: got slow=%b level=%b, expected slow=1 level=%b",
               edge_n, slow_clock, walk_level, exp_l);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({slow_clock, tick, walk_level, walk_press, sensor_level} !== 5'b0) begin
      errors++;
      $display("FAIL midop_async: got outs=%b, expected 00000",
               {slow_clock, tick, walk_level, walk_press, sensor_level});
    end
    repeat (3) @(posedge master_clock);
    #1;
    checks++;
    if ({slow_clock, tick, walk_level, walk_press, sensor_level} !== 5'b0) begin
      errors++;
      $display("FAIL midop_held: got outs=%b, expected 00000",
               {slow_clock, tick, walk_level, walk_press, sensor_level});
    end
    @(negedge master_clock);
    reset  = 1'b1;
    edge_n = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      exp_l    = (edge_n >= 1 + OFS);
      exp_p    = (edge_n == 1 + OFS);
      exp_slow = (edge_n >= 4) && (edge_n < 8);
      exp_tick = (edge_n == 4);
      checks++;
      if ({slow_clock, tick, walk_level, walk_press} !== {exp_slow, exp_tick, exp_l, exp_p}) begin
        errors++;
        $display("FAIL midop_restart edge %0d: got slow/tick/level/press=%b, expected %b",
                 edge_n, {slow_clock, tick, walk_level, walk_press},
                 {exp_slow, exp_tick, exp_l, exp_p});
      end
    end
  endtask

  task automatic test_simultaneous();
    logic exp_l;
    logic exp_tick;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      walk_raw   = (edge_n >= 2);
      sensor_raw = (edge_n >= 2);
      step();
      exp_l    = (edge_n >= 3 + OFS);
      exp_tick = ((edge_n % 8) == 4);
      checks++;
      if ({tick, walk_level, sensor_level} !== {exp_tick, exp_l, exp_l}) begin
        errors++;
        $display("FAIL simultaneous edge %0d: got tick/walk/sensor=%b, expected %b",
                 edge_n, {tick, walk_level, sensor_level}, {exp_tick, exp_l, exp_l});
      end
    end
  endtask

  initial begin
    reset      = 1'b1;
    walk_raw   = 1'b0;
    sensor_raw = 1'b0;
    #1;
    reset = 1'b0;
    test_reset();
    test_divider();
    test_walk();
    test_glitch();
    test_bounce();
    test_reset_midop();
    test_simultaneous();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
